// File: rtl/boron_pkg.sv
// Shared constants and key-rotation helpers for the boron add-round-key stage.
package boron_pkg;

    localparam int BLOCK_W_DEF = 64;
    localparam int KEY_W_DEF   = 80;

    // Widest key the rotation helpers handle; keys are zero-extended to this.
    localparam int KEY_MAX = 128;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    // Rotate the low 'width' bits of key left by 'amount'; upper bits must be zero.
    function automatic logic [KEY_MAX-1:0] rotl_key(input logic [KEY_MAX-1:0] key,
                                                    input int width, input int amount);
        logic [KEY_MAX-1:0] mask;
        mask = {KEY_MAX{1'b1}} >> (KEY_MAX - width);
        return ((key << amount) | (key >> (width - amount))) & mask;
    endfunction

    // Rotate the low 'width' bits of key right by 'amount'; upper bits must be zero.
    function automatic logic [KEY_MAX-1:0] rotr_key(input logic [KEY_MAX-1:0] key,
                                                    input int width, input int amount);
        logic [KEY_MAX-1:0] mask;
        mask = {KEY_MAX{1'b1}} >> (KEY_MAX - width);
        return ((key >> amount) | (key << (width - amount))) & mask;
    endfunction

endpackage

// File: rtl/boron_skid_fifo2.sv
// Two-entry valid/ready FIFO. Exposes the next-cycle full flag so the
// producer can register its ready without a combinational path from pop.
module boron_skid_fifo2 #(
    parameter int WIDTH = 69
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             full_next
);

    logic [WIDTH-1:0] head, tail, head_next, tail_next;
    logic [1:0]       count, count_next;
    logic             pop, push_ok;

    assign pop       = (count != 2'd0) && pop_ready;
    assign push_ok   = push && ((count != 2'd2) || pop);
    assign out_valid = (count != 2'd0);
    assign out_data  = head;
    assign full_next = (count_next == 2'd2);

    // Next-state for the two slots and occupancy; head is always the oldest entry.
    always_comb begin
        head_next  = head;
        tail_next  = tail;
        count_next = count;
        case ({push_ok, pop})
            2'b10: begin
                if (count == 2'd0) head_next = push_data;
                else               tail_next = push_data;
                count_next = count + 2'd1;
            end
            2'b01: begin
                head_next  = tail;
                count_next = count - 2'd1;
            end
            2'b11: begin
                if (count == 2'd2) begin
                    head_next = tail;
                    tail_next = push_data;
                end else begin
                    head_next = push_data;
                end
            end
            default: ;
        endcase
    end

    // Slot and occupancy registers; reset drops any queued blocks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= 2'd0;
        end else begin
            head  <= head_next;
            tail  <= tail_next;
            count <= count_next;
        end
    end

endmodule

// File: rtl/boron_ark_pipe.sv
// Add-round-key stage: XORs each accepted block with the live round key and
// then steps the key schedule forward (encrypt) or backward (decrypt).
module boron_ark_pipe
    import boron_pkg::*;
#(
    parameter int BLOCK_W = BLOCK_W_DEF,
    parameter int KEY_W   = KEY_W_DEF,
    parameter int ROUNDS  = 25,
    parameter int RC_W    = 5,
    parameter int RC_LSB  = 59,
    parameter int KEY_ROT = 13
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               key_load_i,
    input  logic [KEY_W-1:0]   key_i,
    input  logic               mode_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [BLOCK_W-1:0] data_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [BLOCK_W-1:0] data_o,
    output logic [RC_W-1:0]    round_o,
    output logic               done_o
);

    logic [KEY_W-1:0]        rk, rk_next;
    logic [RC_W-1:0]         round, round_next, round_inc;
    logic                    mode, mode_next, done_next;
    logic                    accept, last_round, fifo_full_next, in_ready_next;
    logic [BLOCK_W+RC_W-1:0] fifo_out;

    assign accept     = in_valid_i && in_ready_o;
    assign round_inc  = round + RC_W'(1);
    assign last_round = (mode == MODE_ENC) ? (round == RC_W'(ROUNDS)) : (round == '0);

    // Key schedule step on accept; a coincident load wins over the step.
    always_comb begin
        rk_next    = rk;
        round_next = round;
        mode_next  = mode;
        done_next  = done_o;
        if (accept) begin
            if (last_round) begin
                done_next = 1'b1;
            end else if (mode == MODE_ENC) begin
                rk_next    = KEY_W'(rotl_key(KEY_MAX'(rk), KEY_W, KEY_ROT))
                             ^ (KEY_W'(round_inc) << RC_LSB);
                round_next = round_inc;
            end else begin
                rk_next    = KEY_W'(rotr_key(KEY_MAX'(rk ^ (KEY_W'(round) << RC_LSB)),
                                             KEY_W, KEY_ROT));
                round_next = round - RC_W'(1);
            end
        end
        if (key_load_i) begin
            rk_next    = key_i;
            mode_next  = mode_i;
            round_next = (mode_i == MODE_DEC) ? RC_W'(ROUNDS) : '0;
            done_next  = 1'b0;
        end
        in_ready_next = !done_next && !fifo_full_next;
    end

    // Key, round counter, mode, done flag and registered ready.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rk         <= '0;
            round      <= '0;
            mode       <= MODE_ENC;
            done_o     <= 1'b1;
            in_ready_o <= 1'b0;
        end else begin
            rk         <= rk_next;
            round      <= round_next;
            mode       <= mode_next;
            done_o     <= done_next;
            in_ready_o <= in_ready_next;
        end
    end

    boron_skid_fifo2 #(
        .WIDTH(BLOCK_W + RC_W)
    ) u_fifo (
        .clk       (clk_i),
        .rst       (rst_i),
        .push      (accept),
        .push_data ({data_i ^ rk[BLOCK_W-1:0], round}),
        .pop_ready (out_ready_i),
        .out_valid (out_valid_o),
        .out_data  (fifo_out),
        .full_next (fifo_full_next)
    );

    assign data_o  = fifo_out[BLOCK_W+RC_W-1:RC_W];
    assign round_o = fifo_out[RC_W-1:0];

endmodule

// File: tb/tb_boron_ark_pipe.sv
// Directed bench for boron_ark_pipe with a scoreboard fed at accept time.
module tb_boron_ark_pipe;

    localparam int BW = 64;
    localparam int KW = 80;
    localparam int RW = 5;
    localparam int NR = 25;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          key_load = 1'b0;
    logic [KW-1:0] key = '0;
    logic          mode = 1'b0;
    logic          in_valid = 1'b0;
    logic [BW-1:0] din = '0;
    logic          out_ready = 1'b0;
    logic          in_ready, out_valid, done;
    logic [BW-1:0] dout;
    logic [RW-1:0] rnd;

    int n_checks = 0;
    int n_fail   = 0;

    logic [BW+RW-1:0] sb[$];
    logic [BW-1:0]    obs_data[$];
    logic [RW-1:0]    obs_round[$];
    logic [BW-1:0]    rec[$];
    logic [BW+RW-1:0] mon_exp;

    logic [KW-1:0] m_rk = '0;
    logic [RW-1:0] m_round = '0;
    logic          m_mode = 1'b0;
    logic          m_done = 1'b1;

    always #5 clk = ~clk;

    boron_ark_pipe dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .key_load_i  (key_load),
        .key_i       (key),
        .mode_i      (mode),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .data_i      (din),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .data_o      (dout),
        .round_o     (rnd),
        .done_o      (done)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, required 0x%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: pops the scoreboard on every output handshake.
    always @(negedge clk) begin
        #1;
        if (out_valid && out_ready) begin
            n_checks++;
            assert (sb.size() > 0) else begin
                n_fail++;
                $error("FAIL unexpected_output: observed data 0x%0h round %0d, required no output",
                       dout, rnd);
            end
            if (sb.size() > 0) begin
                mon_exp = sb.pop_front();
                chk("out_data", 128'(dout), 128'(mon_exp[BW+RW-1:RW]));
                chk("out_round", 128'(rnd), 128'(mon_exp[RW-1:0]));
            end
            obs_data.push_back(dout);
            obs_round.push_back(rnd);
        end
    end

    task automatic model_advance();
        logic [KW-1:0] t;
        if (m_mode == 1'b0) begin
            if (m_round == RW'(NR)) m_done = 1'b1;
            else begin
                m_round = m_round + 5'd1;
                m_rk = {m_rk[KW-14:0], m_rk[KW-1:KW-13]};
                m_rk[63:59] = m_rk[63:59] ^ m_round;
            end
        end else begin
            if (m_round == '0) m_done = 1'b1;
            else begin
                t = m_rk;
                t[63:59] = t[63:59] ^ m_round;
                m_rk = {t[12:0], t[KW-1:13]};
                m_round = m_round - 5'd1;
            end
        end
    endtask

    task automatic step(input logic v, input logic [BW-1:0] d, input logic ld,
                        input logic [KW-1:0] k, input logic m, input logic rdy);
        @(negedge clk);
        in_valid = v; din = d; key_load = ld; key = k; mode = m; out_ready = rdy;
        if (v && in_ready) begin
            chk("accept_while_done", 128'(in_ready), 128'(!m_done));
            sb.push_back({d ^ m_rk[BW-1:0], m_round});
            model_advance();
        end
        if (ld) begin
            m_rk = k; m_mode = m; m_done = 1'b0;
            m_round = m ? RW'(NR) : '0;
        end
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, '0, 1'b0, '0, 1'b0, rdy);
    endtask

    task automatic load(input logic [KW-1:0] k, input logic m);
        step(1'b0, '0, 1'b1, k, m, 1'b1);
    endtask

    task automatic drain();
        for (int i = 0; i < 20; i++) begin
            if (sb.size() == 0) break;
            idle(1'b1);
            #2;
        end
        chk("drain_empty", 128'(sb.size()), 128'(0));
    endtask

    function automatic logic [KW-1:0] rand_key();
        return KW'({$urandom(), $urandom(), $urandom()});
    endfunction

    initial begin
        logic [KW-1:0] ka, kb;
        logic [BW-1:0] d3;

        // Reset state
        #1 rst = 1'b1;
        #1;
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_data", 128'(dout), 128'(0));
        chk("rst_round", 128'(rnd), 128'(0));
        chk("rst_in_ready", 128'(in_ready), 128'(0));
        chk("rst_done", 128'(done), 128'(1));
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        idle(1'b1);
        chk("idle_no_key_ready", 128'(in_ready), 128'(0));

        // Encrypt, first two blocks with an all-zero key
        obs_data.delete(); obs_round.delete();
        load('0, 1'b0);
        step(1'b1, 64'h0123456789ABCDEF, 1'b0, '0, 1'b0, 1'b1);
        step(1'b1, 64'h0123456789ABCDEF, 1'b0, '0, 1'b0, 1'b1);
        drain();
        chk("enc_count", 128'(obs_data.size()), 128'(2));
        chk("enc_data0", 128'(obs_data[0]), 128'(64'h0123456789ABCDEF));
        chk("enc_round0", 128'(obs_round[0]), 128'(0));
        chk("enc_data1", 128'(obs_data[1]), 128'(64'h0923456789ABCDEF));
        chk("enc_round1", 128'(obs_round[1]), 128'(1));

        // Key exhaustion: 27 offered back to back, 26 accepted
        obs_data.delete(); obs_round.delete();
        load(rand_key(), 1'b0);
        for (int i = 0; i < 27; i++) step(1'b1, {$urandom(), $urandom()}, 1'b0, '0, 1'b0, 1'b1);
        drain();
        chk("exh_count", 128'(obs_data.size()), 128'(26));
        chk("exh_last_round", 128'(obs_round[25]), 128'(25));
        chk("exh_done", 128'(done), 128'(1));
        chk("exh_ready", 128'(in_ready), 128'(0));
        for (int i = 0; i < 3; i++) step(1'b1, '0, 1'b0, '0, 1'b0, 1'b1);
        chk("exh_ready_hold", 128'(in_ready), 128'(0));

        // Encrypt/decrypt round trip
        obs_data.delete(); obs_round.delete();
        load(rand_key(), 1'b0);
        for (int i = 0; i < 26; i++) step(1'b1, '0, 1'b0, '0, 1'b0, 1'b1);
        drain();
        rec = obs_data;
        chk("rt_enc_count", 128'(rec.size()), 128'(26));
        obs_data.delete(); obs_round.delete();
        load(m_rk, 1'b1);
        for (int i = 0; i < 26; i++) step(1'b1, '0, 1'b0, '0, 1'b0, 1'b1);
        drain();
        chk("rt_dec_count", 128'(obs_data.size()), 128'(26));
        for (int i = 0; i < 26; i++) begin
            chk("rt_dec_key", 128'(obs_data[i]), 128'(rec[25-i]));
            chk("rt_dec_round", 128'(obs_round[i]), 128'(25 - i));
        end
        chk("rt_dec_done", 128'(done), 128'(1));

        // Backpressure: 5 cycles with output stalled
        obs_data.delete(); obs_round.delete();
        load(rand_key(), 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, {$urandom(), $urandom()}, 1'b0, '0, 1'b0, 1'b0);
        chk("bp_held", 128'(sb.size()), 128'(2));
        chk("bp_ready", 128'(in_ready), 128'(0));
        chk("bp_valid", 128'(out_valid), 128'(1));
        drain();
        chk("bp_count", 128'(obs_data.size()), 128'(2));
        chk("bp_round0", 128'(obs_round[0]), 128'(0));
        chk("bp_round1", 128'(obs_round[1]), 128'(1));
        chk("bp_ready_after", 128'(in_ready), 128'(1));

        // Load coincident with an accept
        obs_data.delete(); obs_round.delete();
        ka = rand_key(); kb = rand_key(); d3 = {$urandom(), $urandom()};
        load(ka, 1'b0);
        step(1'b1, {$urandom(), $urandom()}, 1'b0, '0, 1'b0, 1'b1);
        step(1'b1, {$urandom(), $urandom()}, 1'b0, '0, 1'b0, 1'b1);
        step(1'b1, {$urandom(), $urandom()}, 1'b1, kb, 1'b0, 1'b1);
        step(1'b1, d3, 1'b0, '0, 1'b0, 1'b1);
        drain();
        chk("ld_count", 128'(obs_data.size()), 128'(4));
        chk("ld_round_old", 128'(obs_round[2]), 128'(2));
        chk("ld_round_new", 128'(obs_round[3]), 128'(0));
        chk("ld_data_new", 128'(obs_data[3]), 128'(d3 ^ kb[BW-1:0]));

        // Reset mid-stream with two blocks queued
        obs_data.delete(); obs_round.delete();
        load(rand_key(), 1'b0);
        step(1'b1, {$urandom(), $urandom()}, 1'b0, '0, 1'b0, 1'b0);
        step(1'b1, {$urandom(), $urandom()}, 1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("mid_queued", 128'(out_valid), 128'(1));
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_valid", 128'(out_valid), 128'(0));
        chk("mid_rst_done", 128'(done), 128'(1));
        chk("mid_rst_ready", 128'(in_ready), 128'(0));
        chk("mid_rst_data", 128'(dout), 128'(0));
        sb.delete();
        m_done = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) idle(1'b1);
        #2;
        chk("mid_no_output", 128'(obs_data.size()), 128'(0));
        chk("mid_done_hold", 128'(done), 128'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
